// File: rtl/dtrk_pkg.sv
// Shared definitions for the EPROM emulator host loader: opcodes, FSM
// encodings and the write-count decode helper.
package dtrk_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;   // holds 1..16 words per write command

  localparam logic [BYTE_W-1:0] OP_NOP        = 8'h00;
  localparam logic [BYTE_W-1:0] OP_RSTADDR    = 8'h01;
  localparam logic [BYTE_W-1:0] OP_SETADDR    = 8'h02;
  localparam logic [BYTE_W-1:0] OP_LOAD       = 8'h10;
  localparam logic [BYTE_W-1:0] OP_RUN        = 8'h11;
  localparam logic [BYTE_W-1:0] OP_WRITE_MASK = 8'hF0;
  localparam logic [BYTE_W-1:0] OP_WRITE      = 8'h20;

  // FT240X read strobe states
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOW,
    RD_GAP
  } rd_state_t;

  // Command decoder / SRAM write states
  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    ADDR_B0,
    ADDR_B1,
    ADDR_B2,
    DATA_HI,
    DATA_LO,
    WR_SETUP,
    WR_PULSE,
    WR_END
  } seq_state_t;

  // Low nibble of a write opcode gives the word count; 0 encodes 16.
  function automatic logic [CNT_W-1:0] write_count(input logic [3:0] nib);
    write_count = (nib == 4'h0) ? CNT_W'(16) : CNT_W'(nib);
  endfunction

endpackage

// File: rtl/host_load_sequencer_if.sv
// Bundles the FT240X FIFO pins, the SRAM write pins and the loader status
// flags of host_load_sequencer.
//  master : the sequencer (reads FT240X, drives SRAM and status)
//  slave  : the FT240X / SRAM side
interface host_load_sequencer_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [7:0]        ft240x_d;
  logic              ft240x_RXF;
  logic              ft240x_nRD;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic              sram_nCS;
  logic              sram_nWE;
  logic              sram_own;
  logic              busy;
  logic              cmd_err;

  modport master (
    input  ft240x_d, ft240x_RXF,
    output ft240x_nRD,
    output sram_addr, sram_wdata, sram_nCS, sram_nWE, sram_own,
    output busy, cmd_err
  );

  modport slave (
    output ft240x_d, ft240x_RXF,
    input  ft240x_nRD,
    input  sram_addr, sram_wdata, sram_nCS, sram_nWE, sram_own,
    input  busy, cmd_err
  );
endinterface

// File: rtl/ft240x_rd_port.sv
// FT240X receive port: strobes nRD low for RD_LOW_CYC cycles when a byte is
// available, latches the data on the last low cycle, then holds nRD high for
// at least one gap cycle. The byte is offered on byte_valid until byte_ack;
// no new read starts while a byte is pending.
// Ports:
//  clk24MHz, reset : clock, synchronous active-high reset
//  rxf             : FT240X RXF (0 = byte available)
//  d               : FT240X data bus
//  nrd             : FT240X read strobe, active low (registered)
//  byte_data       : latched byte
//  byte_valid      : byte_data holds an unconsumed byte
//  byte_ack        : consumer takes the byte this cycle
module ft240x_rd_port
  import dtrk_pkg::*;
#(
  parameter int unsigned RD_LOW_CYC = 2
) (
  input  logic              clk24MHz,
  input  logic              reset,
  input  logic              rxf,
  input  logic [BYTE_W-1:0] d,
  output logic              nrd,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ack
);

  localparam int unsigned CYC_W = (RD_LOW_CYC > 1) ? $clog2(RD_LOW_CYC) : 1;

  rd_state_t         state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BYTE_W-1:0] data_d;
  logic              valid_d;
  logic              nrd_d;

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    data_d  = byte_data;
    valid_d = byte_valid & ~byte_ack;
    case (state_q)
      RD_IDLE: begin
        if (!rxf && !byte_valid) begin
          state_d = RD_LOW;
          cyc_d   = '0;
        end
      end
      RD_LOW: begin
        if (cyc_q == CYC_W'(RD_LOW_CYC - 1)) begin
          data_d  = d;
          valid_d = 1'b1;
          state_d = RD_GAP;
        end else begin
          cyc_d = CYC_W'(cyc_q + CYC_W'(1));
        end
      end
      RD_GAP:  state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
    nrd_d = (state_d != RD_LOW);
  end

  // State and output registers
  always_ff @(posedge clk24MHz) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      cyc_q      <= '0;
      nrd        <= 1'b1;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      nrd        <= nrd_d;
      byte_data  <= data_d;
      byte_valid <= valid_d;
    end
  end

endmodule

// File: rtl/host_load_sequencer.sv
// Host-side command sequencer for the EPROM emulator CPLD. Pulls command and
// data bytes from the FT240X, decodes them and performs 16-bit word writes
// into the emulation SRAM. Owns the load/run flag used by the top level to
// mux the SRAM between this block and the target bus.
// Ports:
//  clk24MHz : system clock, rising edge
//  reset    : synchronous active-high reset
//  bus      : master view of host_load_sequencer_if
//             (ft240x_d/RXF/nRD, sram_addr/wdata/nCS/nWE/own, busy, cmd_err)
module host_load_sequencer
  import dtrk_pkg::*;
#(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned RD_LOW_CYC = 2,
  parameter int unsigned WR_LOW_CYC = 1
) (
  input  logic                  clk24MHz,
  input  logic                  reset,
  host_load_sequencer_if.master bus
);

  localparam int unsigned WCYC_W = (WR_LOW_CYC > 1) ? $clog2(WR_LOW_CYC) : 1;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ack_c;

  seq_state_t        state_q, state_d;
  logic [BYTE_W-1:0] op_q, op_d;
  logic [BYTE_W-1:0] b0_q, b0_d;
  logic [BYTE_W-1:0] b1_q, b1_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCYC_W-1:0] wcyc_q, wcyc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              own_q, own_d;
  logic              err_q, err_d;
  logic              ncs_q, ncs_d;
  logic              nwe_q, nwe_d;
  logic              busy_q, busy_d;

  ft240x_rd_port #(
    .RD_LOW_CYC (RD_LOW_CYC)
  ) u_rd_port (
    .clk24MHz   (clk24MHz),
    .reset      (reset),
    .rxf        (bus.ft240x_RXF),
    .d          (bus.ft240x_d),
    .nrd        (bus.ft240x_nRD),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack_c)
  );

  // Command decode, address pointer and SRAM write sequencing
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    wcyc_d     = wcyc_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    own_d      = own_q;
    err_d      = err_q;
    byte_ack_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (byte_valid) begin
          byte_ack_c = 1'b1;
          op_d       = byte_data;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if ((op_q & OP_WRITE_MASK) == OP_WRITE) begin
          // Data bytes are always consumed so the stream stays aligned,
          // even when the write itself is refused in run mode.
          cnt_d   = write_count(op_q[3:0]);
          state_d = DATA_HI;
          if (!own_q) err_d = 1'b1;
        end else begin
          case (op_q)
            OP_NOP:     state_d = IDLE;
            OP_RSTADDR: addr_d  = '0;
            OP_SETADDR: state_d = ADDR_B0;
            OP_LOAD:    own_d   = 1'b1;
            OP_RUN:     own_d   = 1'b0;
            default:    err_d   = 1'b1;
          endcase
        end
      end
      ADDR_B0: begin
        if (byte_valid) begin
          byte_ack_c = 1'b1;
          b0_d       = byte_data;
          state_d    = ADDR_B1;
        end
      end
      ADDR_B1: begin
        if (byte_valid) begin
          byte_ack_c = 1'b1;
          b1_d       = byte_data;
          state_d    = ADDR_B2;
        end
      end
      ADDR_B2: begin
        if (byte_valid) begin
          byte_ack_c = 1'b1;
          // Upper bits of the 24-bit byte triple beyond ADDR_W are dropped.
          addr_d     = ADDR_W'({b0_q, b1_q, byte_data});
          state_d    = IDLE;
        end
      end
      DATA_HI: begin
        if (byte_valid) begin
          byte_ack_c = 1'b1;
          hi_d       = byte_data;
          state_d    = DATA_LO;
        end
      end
      DATA_LO: begin
        if (byte_valid) begin
          byte_ack_c = 1'b1;
          if (own_q) begin
            wdata_d = {hi_q, byte_data};
            state_d = WR_SETUP;
          end else begin
            cnt_d   = CNT_W'(cnt_q - CNT_W'(1));
            state_d = (cnt_q == CNT_W'(1)) ? IDLE : DATA_HI;
          end
        end
      end
      WR_SETUP: begin
        wcyc_d  = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (wcyc_q == WCYC_W'(WR_LOW_CYC - 1)) begin
          state_d = WR_END;
        end else begin
          wcyc_d = WCYC_W'(wcyc_q + WCYC_W'(1));
        end
      end
      WR_END: begin
        addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
        cnt_d   = CNT_W'(cnt_q - CNT_W'(1));
        state_d = (cnt_q == CNT_W'(1)) ? IDLE : DATA_HI;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered against the next state so they line up with it.
    ncs_d  = !(state_d inside {WR_SETUP, WR_PULSE, WR_END});
    nwe_d  = (state_d != WR_PULSE);
    busy_d = (state_d != IDLE) || (cnt_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk24MHz) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      wcyc_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      own_q   <= 1'b0;
      err_q   <= 1'b0;
      ncs_q   <= 1'b1;
      nwe_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      wcyc_q  <= wcyc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      own_q   <= own_d;
      err_q   <= err_d;
      ncs_q   <= ncs_d;
      nwe_q   <= nwe_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_nCS   = ncs_q;
  assign bus.sram_nWE   = nwe_q;
  assign bus.sram_own   = own_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_err    = err_q;

endmodule

// File: tb/tb_host_load_sequencer.sv
// Bench for host_load_sequencer: an FT240X FIFO model feeds a byte stream, a
// command-level reference model predicts SRAM writes and final status, and a
// negedge monitor checks strobe timing and scoreboards every write.
module tb_host_load_sequencer;

  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned RD_LOW_CYC = 2;
  localparam int unsigned WR_LOW_CYC = 1;
  localparam int          ADDR_SPAN  = 1 << ADDR_W;
  localparam int          WAIT_MAX   = 20000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic clk24MHz = 1'b0;
  logic reset    = 1'b1;
  always #5 clk24MHz = ~clk24MHz;

  host_load_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  host_load_sequencer #(
    .ADDR_W     (ADDR_W),
    .RD_LOW_CYC (RD_LOW_CYC),
    .WR_LOW_CYC (WR_LOW_CYC)
  ) dut (
    .clk24MHz (clk24MHz),
    .reset    (reset),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Byte stream offered by the FIFO model; rd_idx is the next unread byte.
  logic [7:0] stream [$];
  int         rd_idx = 0;
  // Expected SRAM writes; exp_idx is the next one the monitor will match.
  wr_t        exp_wr [$];
  int         exp_idx = 0;
  bit         rand_stall = 1'b0;

  // Reference model state (command interpreter view)
  int         m_phase = 0;  // 0 opcode, 1..3 address bytes, 4 data hi, 5 data lo
  int         m_cnt   = 0;
  int         m_addr  = 0;
  int         m_abuf  = 0;
  bit         m_own   = 1'b0;
  bit         m_err   = 1'b0;
  logic [7:0] m_hi    = 8'h00;

  // Monitor state
  logic prev_nrd = 1'b1;
  logic prev_rxf = 1'b1;
  logic prev_nwe = 1'b1;
  int   low_run  = 0;
  int   we_run   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_addr  = 0;
    m_abuf  = 0;
    m_own   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    case (m_phase)
      0: begin
        if (b == 8'h00) begin
          m_phase = 0;
        end else if (b == 8'h01) begin
          m_addr = 0;
        end else if (b == 8'h02) begin
          m_abuf  = 0;
          m_phase = 1;
        end else if (b == 8'h10) begin
          m_own = 1'b1;
        end else if (b == 8'h11) begin
          m_own = 1'b0;
        end else if (b[7:4] == 4'h2) begin
          m_cnt   = (b[3:0] == 4'h0) ? 16 : int'(b[3:0]);
          m_phase = 4;
          if (!m_own) m_err = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      1, 2, 3: begin
        m_abuf = (m_abuf << 8) | int'(b);
        if (m_phase == 3) begin
          m_addr  = m_abuf % ADDR_SPAN;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      4: begin
        m_hi    = b;
        m_phase = 5;
      end
      default: begin
        if (m_own) begin
          w.addr = ADDR_W'(m_addr);
          w.data = {m_hi, b};
          exp_wr.push_back(w);
          m_addr = (m_addr + 1) % ADDR_SPAN;
        end
        m_cnt--;
        m_phase = (m_cnt == 0) ? 0 : 4;
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    stream.push_back(b);
    model_byte(b);
  endtask

  // FT240X model, strobe protocol checks and write scoreboard
  always @(negedge clk24MHz) begin
    logic stall;
    wr_t  e;
    if (!bus.ft240x_nRD) begin
      if (prev_nrd) check("nrd_while_rxf_high", 32'(prev_rxf), 32'd0);
      low_run++;
    end else begin
      if (!prev_nrd) begin
        check("nrd_low_cycles", 32'(low_run), 32'(RD_LOW_CYC));
        rd_idx++;
      end
      low_run = 0;
    end
    prev_nrd = bus.ft240x_nRD;

    if (!bus.sram_nCS) check("ncs_in_run_mode", 32'(bus.sram_own), 32'd1);
    if (!bus.sram_nWE) begin
      check("nwe_without_ncs", 32'(bus.sram_nCS), 32'd0);
      if (prev_nwe) begin
        if (exp_idx < exp_wr.size()) begin
          e = exp_wr[exp_idx];
          check("wr_addr", 32'(bus.sram_addr), 32'(e.addr));
          check("wr_data", 32'(bus.sram_wdata), 32'(e.data));
          exp_idx++;
        end else begin
          check("unexpected_write", 32'(bus.sram_addr), 32'hFFFF_FFFF);
        end
      end
      we_run++;
    end else begin
      if (!prev_nwe) check("nwe_low_cycles", 32'(we_run), 32'(WR_LOW_CYC));
      we_run = 0;
    end
    prev_nwe = bus.sram_nWE;

    stall = rand_stall && ($urandom_range(0, 5) == 0);
    bus.ft240x_RXF = (rd_idx >= stream.size()) || stall;
    bus.ft240x_d   = (rd_idx < stream.size()) ? stream[rd_idx] : 8'h00;
    prev_rxf = bus.ft240x_RXF;
  end

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk24MHz);
    check("rst_nrd", 32'(bus.ft240x_nRD), 32'd1);
    check("rst_ncs", 32'(bus.sram_nCS), 32'd1);
    check("rst_nwe", 32'(bus.sram_nWE), 32'd1);
    check("rst_own", 32'(bus.sram_own), 32'd0);
    check("rst_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_wdata", 32'(bus.sram_wdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.cmd_err), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // Wait for the stream to be consumed and the DUT to go idle, then compare state.
  task automatic drain(input string tag);
    int n = 0;
    while (rd_idx < stream.size() && n < WAIT_MAX) begin
      @(negedge clk24MHz);
      n++;
    end
    repeat (3) @(negedge clk24MHz);
    while (bus.busy && n < WAIT_MAX) begin
      @(negedge clk24MHz);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= WAIT_MAX), 32'd0);
    repeat (2) @(negedge clk24MHz);
    check({tag, "_addr"}, 32'(bus.sram_addr), 32'(m_addr));
    check({tag, "_own"}, 32'(bus.sram_own), 32'(m_own));
    check({tag, "_err"}, 32'(bus.cmd_err), 32'(m_err));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_wr.size() - exp_idx), 32'd0);
  endtask

  initial begin
    int         n;
    logic [7:0] b0;
    logic [7:0] op;
    int         words;

    repeat (2) @(negedge clk24MHz);
    reset_dut();

    // Load mode, 16 words from address 0
    send(8'h10); send(8'h01); send(8'h20);
    for (int i = 0; i < 16; i++) begin
      send(8'h12); send(8'h34);
    end
    drain("burst16");

    // Short writes then back to run mode
    send(8'h00); send(8'h21); send(8'h55); send(8'hAA);
    send(8'h22); send(8'hAA); send(8'h55); send(8'hDC); send(8'hAB);
    send(8'h11);
    drain("short_writes");

    // Address wrap at the top of SRAM
    send(8'h10); send(8'h02); send(8'h03); send(8'hFF); send(8'hFF);
    send(8'h22); send(8'h11); send(8'h11); send(8'h22); send(8'h22);
    drain("wrap");

    // FIFO runs dry between the two bytes of a word
    send(8'h21); send(8'h12);
    n = 0;
    while (rd_idx < stream.size() && n < WAIT_MAX) begin
      @(negedge clk24MHz);
      n++;
    end
    check("stall_reach_timeout", 32'(n >= WAIT_MAX), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk24MHz);
      check("stall_nrd", 32'(bus.ft240x_nRD), 32'd1);
      check("stall_nwe", 32'(bus.sram_nWE), 32'd1);
    end
    check("stall_busy", 32'(bus.busy), 32'd1);
    send(8'h34);
    drain("stall");

    // Write refused in run mode, followed by a nop
    send(8'h11); send(8'h21); send(8'hAB); send(8'hCD); send(8'h00);
    drain("run_write");

    // Unknown opcode on a clean error flag
    reset_dut();
    send(8'h7F);
    drain("bad_op");

    // Reset in the middle of a write pulse
    reset_dut();
    send(8'h10); send(8'h21); send(8'h12); send(8'h34);
    n = 0;
    while (bus.sram_nWE && n < WAIT_MAX) begin
      @(negedge clk24MHz);
      n++;
    end
    check("pulse_reach_timeout", 32'(n >= WAIT_MAX), 32'd0);
    reset = 1'b1;
    @(negedge clk24MHz);
    check("midwr_nwe", 32'(bus.sram_nWE), 32'd1);
    check("midwr_ncs", 32'(bus.sram_nCS), 32'd1);
    check("midwr_nrd", 32'(bus.ft240x_nRD), 32'd1);
    check("midwr_own", 32'(bus.sram_own), 32'd0);
    check("midwr_addr", 32'(bus.sram_addr), 32'd0);
    check("midwr_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk24MHz);

    // Randomized command stream with random FIFO stalls
    reset_dut();
    rand_stall = 1'b1;
    send(8'h10);
    for (int c = 0; c < 48; c++) begin
      case ($urandom_range(0, 9))
        0: send(8'h00);
        1: send(8'h01);
        2: begin
          send(8'h02);
          if ($urandom_range(0, 1) == 1) begin
            b0 = 8'(8'hFF - 8'($urandom_range(0, 3)));
            send(8'h03); send(8'hFF); send(b0);
          end else begin
            send(8'($urandom_range(0, 255)));
            send(8'($urandom_range(0, 255)));
            send(8'($urandom_range(0, 255)));
          end
        end
        3: send(8'h10);
        4: if ($urandom_range(0, 2) == 0) send(8'h11);
        9: begin
          if ($urandom_range(0, 3) == 0) send(8'(8'h30 + 8'($urandom_range(0, 207))));
          else send(8'h10);
        end
        default: begin
          op = 8'(8'h20 | 8'($urandom_range(0, 15)));
          send(op);
          words = (op[3:0] == 4'h0) ? 16 : int'(op[3:0]);
          for (int w = 0; w < words; w++) begin
            send(8'($urandom_range(0, 255)));
            send(8'($urandom_range(0, 255)));
          end
        end
      endcase
      if (c % 8 == 7) drain("random");
    end
    drain("random_end");
    rand_stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
